// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Hardwired control sequencer for the Mini SRC datapath. It runs instruction
//   fetch (T0..T2), decodes the IR, and steps the one-hot register, bus and
//   ALU strobes for each instruction class (3-operand, MUL/DIV with HI/LO
//   write-back, unary NEG/NOT). Bad opcodes or out-of-range register fields
//   are trapped: they skip every write-back and finish with IllegalOp.
//
// Parameters
//   REG_COUNT  number of general registers, width of Rout/Rin (2..16)
//   MEM_WAIT   extra T1 cycles holding Read/MDRin before T2 (0..7)
//
// Ports
//   i_clock      rising-edge clock
//   i_reset      synchronous, active-high reset
//   i_start      begin one instruction (sampled only in IDLE)
//   i_ir[31:0]   IR register contents, valid from T3 onward
//   o_pcout, o_zlowout, o_zhighout, o_mdrout        bus-drive strobes
//   o_marin, o_zin, o_pcin, o_mdrin, o_irin, o_yin,
//   o_hiin, o_loin                                  register load strobes
//   o_incpc, o_read                                 PC increment / memory read
//   o_rout[REG_COUNT-1:0]  one-hot register bus drive
//   o_rin[REG_COUNT-1:0]   one-hot register load
//   o_aluop[3:0]  ALU operation, valid while o_aluen is high (0 otherwise)
//   o_aluen       ALU operation valid this cycle
//   o_busy        high in every state except IDLE
//   o_done        one-cycle pulse when the instruction completes
//   o_illegalop   one-cycle pulse together with o_done on a trapped instruction
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int REG_COUNT = 16,
  parameter int MEM_WAIT  = 0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [31:0]          i_ir,
  output logic                 o_pcout,
  output logic                 o_zlowout,
  output logic                 o_zhighout,
  output logic                 o_mdrout,
  output logic                 o_marin,
  output logic                 o_zin,
  output logic                 o_pcin,
  output logic                 o_mdrin,
  output logic                 o_irin,
  output logic                 o_yin,
  output logic                 o_hiin,
  output logic                 o_loin,
  output logic                 o_incpc,
  output logic                 o_read,
  output logic [REG_COUNT-1:0] o_rout,
  output logic [REG_COUNT-1:0] o_rin,
  output logic [3:0]           o_aluop,
  output logic                 o_aluen,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_illegalop
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CL_3OP, CL_MULDIV, CL_UNARY, CL_BAD
  } cls_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_wait;
  logic       r_illegal;

  logic [4:0] w_op;
  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;
  cls_t       w_cls;
  logic [3:0] w_aluop;
  logic       w_illegal;
  logic       w_wait_done;
  logic       w_unused;

  assign w_op  = i_ir[31:27];
  assign w_ra  = i_ir[26:23];
  assign w_rb  = i_ir[22:19];
  assign w_rc  = i_ir[18:15];
  // Immediate/constant bits are not used by this sequencer.
  assign w_unused = ^i_ir[14:0];

  function automatic logic reg_ok(input logic [3:0] idx);
    return int'(idx) < REG_COUNT;
  endfunction

  function automatic logic [REG_COUNT-1:0] onehot(input logic [3:0] idx);
    logic [REG_COUNT-1:0] v;
    v = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (int'(idx) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Opcode -> instruction class and ALU operation code.
  always_comb begin
    w_cls   = CL_BAD;
    w_aluop = 4'h0;
    case (w_op)
      5'h03: begin w_cls = CL_3OP;    w_aluop = 4'h2; end
      5'h04: begin w_cls = CL_3OP;    w_aluop = 4'h3; end
      5'h05: begin w_cls = CL_3OP;    w_aluop = 4'h0; end
      5'h06: begin w_cls = CL_3OP;    w_aluop = 4'h1; end
      5'h07: begin w_cls = CL_3OP;    w_aluop = 4'hA; end
      5'h08: begin w_cls = CL_3OP;    w_aluop = 4'hB; end
      5'h09: begin w_cls = CL_3OP;    w_aluop = 4'h7; end
      5'h0A: begin w_cls = CL_3OP;    w_aluop = 4'h8; end
      5'h0B: begin w_cls = CL_3OP;    w_aluop = 4'h9; end
      5'h0F: begin w_cls = CL_MULDIV; w_aluop = 4'h4; end
      5'h10: begin w_cls = CL_MULDIV; w_aluop = 4'h6; end
      5'h11: begin w_cls = CL_UNARY;  w_aluop = 4'hC; end
      5'h12: begin w_cls = CL_UNARY;  w_aluop = 4'hD; end
      default: ;
    endcase
  end

  // Rc is only read by the 3-operand class; Ra/Rb are read by every class.
  assign w_illegal = (w_cls == CL_BAD) || !reg_ok(w_ra) || !reg_ok(w_rb) ||
                     ((w_cls == CL_3OP) && !reg_ok(w_rc));

  assign w_wait_done = (r_wait == 3'(MEM_WAIT));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      // Counts completed T1 cycles; cleared everywhere else so each fetch
      // starts its memory wait from zero.
      if ((r_state == S_T1) && !w_wait_done) r_wait <= r_wait + 3'd1;
      else                                   r_wait <= '0;
      // Trap decision is taken once in T3 and reported in DONE.
      if (r_state == S_T3)        r_illegal <= w_illegal;
      else if (r_state == S_IDLE) r_illegal <= 1'b0;
    end
  end

  always_comb begin
    w_next      = r_state;
    o_pcout     = 1'b0;
    o_zlowout   = 1'b0;
    o_zhighout  = 1'b0;
    o_mdrout    = 1'b0;
    o_marin     = 1'b0;
    o_zin       = 1'b0;
    o_pcin      = 1'b0;
    o_mdrin     = 1'b0;
    o_irin      = 1'b0;
    o_yin       = 1'b0;
    o_hiin      = 1'b0;
    o_loin      = 1'b0;
    o_incpc     = 1'b0;
    o_read      = 1'b0;
    o_rout      = '0;
    o_rin       = '0;
    o_aluop     = 4'h0;
    o_aluen     = 1'b0;
    o_busy      = (r_state != S_IDLE);
    o_done      = 1'b0;
    o_illegalop = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_T0;
      end
      S_T0: begin
        o_pcout = 1'b1;
        o_marin = 1'b1;
        o_incpc = 1'b1;
        o_zin   = 1'b1;
        w_next  = S_T1;
      end
      S_T1: begin
        o_zlowout = 1'b1;
        o_read    = 1'b1;
        o_mdrin   = 1'b1;
        // PC is reloaded once; later wait cycles only hold the read.
        o_pcin    = (r_wait == 3'd0);
        if (w_wait_done) w_next = S_T2;
      end
      S_T2: begin
        o_mdrout = 1'b1;
        o_irin   = 1'b1;
        w_next   = S_T3;
      end
      S_T3: begin
        if (w_illegal) begin
          w_next = S_DONE;
        end else begin
          w_next = S_T4;
          case (w_cls)
            CL_3OP: begin
              o_rout = onehot(w_rb);
              o_yin  = 1'b1;
            end
            CL_MULDIV: begin
              o_rout = onehot(w_ra);
              o_yin  = 1'b1;
            end
            CL_UNARY: begin
              o_rout  = onehot(w_rb);
              o_aluen = 1'b1;
              o_aluop = w_aluop;
              o_zin   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_T4: begin
        w_next = S_T5;
        case (w_cls)
          CL_3OP: begin
            o_rout  = onehot(w_rc);
            o_aluen = 1'b1;
            o_aluop = w_aluop;
            o_zin   = 1'b1;
          end
          CL_MULDIV: begin
            o_rout  = onehot(w_rb);
            o_aluen = 1'b1;
            o_aluop = w_aluop;
            o_zin   = 1'b1;
          end
          CL_UNARY: begin
            o_zlowout = 1'b1;
            o_rin     = onehot(w_ra);
            w_next    = S_DONE;
          end
          default: w_next = S_DONE;
        endcase
      end
      S_T5: begin
        w_next    = S_DONE;
        o_zlowout = 1'b1;
        if (w_cls == CL_MULDIV) begin
          o_loin = 1'b1;
          w_next = S_T6;
        end else begin
          o_rin = onehot(w_ra);
        end
      end
      S_T6: begin
        o_zhighout = 1'b1;
        o_hiin     = 1'b1;
        w_next     = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        o_illegalop = r_illegal;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
//   Three sequencer instances: (REG_COUNT=16, MEM_WAIT=0), (16, 3), (8, 0).
//   Directed instructions are issued one at a time to the selected instance;
//   the expected per-cycle strobe trace is queued at issue and a negedge
//   monitor pops and compares it, checking idle outputs and bus/one-hot
//   rules on every cycle.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

  typedef struct packed {
    logic pcout, zlowout, zhighout, mdrout, marin, zin, pcin, mdrin, irin;
    logic yin, hiin, loin, incpc, read, aluen, busy, done, illegal;
    logic [3:0]  aluop;
    logic [15:0] rout;
    logic [15:0] rin;
  } vec_t;

  typedef enum int {C3, CMD, CUN, CIL} cls_e;

  typedef struct {
    int          idx;
    logic [31:0] ir;
    cls_e        cls;
    logic [3:0]  aop;
    int          lat;
  } tv_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start [3];
  logic [31:0] ir [3];
  int          cur = 0;
  bit          mon_en = 1'b0;
  int          n_vec = 0;
  int          n_miss = 0;
  vec_t        exp_q [$];
  vec_t        cur_act;
  vec_t        mon_e;
  tv_t         tv [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int RC = (g == 2) ? 8 : 16;
    localparam int MW = (g == 1) ? 3 : 0;
    logic pcout, zlowout, zhighout, mdrout, marin, zin, pcin, mdrin, irin;
    logic yin, hiin, loin, incpc, rd, aluen, busy, done, ill;
    logic [3:0]    aluop;
    logic [RC-1:0] rout, rin;
    vec_t          act;

    alu_op_sequencer #(.REG_COUNT(RC), .MEM_WAIT(MW)) u_dut (
      .i_clock(clk), .i_reset(rst), .i_start(start[g]), .i_ir(ir[g]),
      .o_pcout(pcout), .o_zlowout(zlowout), .o_zhighout(zhighout),
      .o_mdrout(mdrout), .o_marin(marin), .o_zin(zin), .o_pcin(pcin),
      .o_mdrin(mdrin), .o_irin(irin), .o_yin(yin), .o_hiin(hiin),
      .o_loin(loin), .o_incpc(incpc), .o_read(rd), .o_rout(rout),
      .o_rin(rin), .o_aluop(aluop), .o_aluen(aluen), .o_busy(busy),
      .o_done(done), .o_illegalop(ill)
    );

    assign act = {pcout, zlowout, zhighout, mdrout, marin, zin, pcin, mdrin, irin,
                  yin, hiin, loin, incpc, rd, aluen, busy, done, ill,
                  aluop, 16'(rout), 16'(rin)};
  end

  always_comb begin
    case (cur)
      1:       cur_act = g_dut[1].act;
      2:       cur_act = g_dut[2].act;
      default: cur_act = g_dut[0].act;
    endcase
  end

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'd0};
  endfunction

  task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s (inst %0d, t=%0t): got %h want %h", name, cur, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("FAIL %s (inst %0d, t=%0t): got %0d want %0d", name, cur, $time, got, want);
    end
  endtask

  // Expected cycle-by-cycle outputs: one idle cycle (issue), fetch, class
  // steps, DONE. limit>0 keeps only the first limit entries.
  task automatic push_trace(input cls_e cls, input logic [3:0] ra, input logic [3:0] rb,
                            input logic [3:0] rc, input logic [3:0] aop,
                            input int mw, input int limit);
    vec_t t [$];
    vec_t v;
    t.push_back('0);
    v = '0; v.busy = 1; v.pcout = 1; v.marin = 1; v.incpc = 1; v.zin = 1; t.push_back(v);
    for (int k = 0; k <= mw; k++) begin
      v = '0; v.busy = 1; v.zlowout = 1; v.read = 1; v.mdrin = 1; v.pcin = (k == 0);
      t.push_back(v);
    end
    v = '0; v.busy = 1; v.mdrout = 1; v.irin = 1; t.push_back(v);
    case (cls)
      C3: begin
        v = '0; v.busy = 1; v.rout = 16'd1 << rb; v.yin = 1; t.push_back(v);
        v = '0; v.busy = 1; v.rout = 16'd1 << rc; v.aluen = 1; v.aluop = aop; v.zin = 1;
        t.push_back(v);
        v = '0; v.busy = 1; v.zlowout = 1; v.rin = 16'd1 << ra; t.push_back(v);
      end
      CMD: begin
        v = '0; v.busy = 1; v.rout = 16'd1 << ra; v.yin = 1; t.push_back(v);
        v = '0; v.busy = 1; v.rout = 16'd1 << rb; v.aluen = 1; v.aluop = aop; v.zin = 1;
        t.push_back(v);
        v = '0; v.busy = 1; v.zlowout = 1; v.loin = 1; t.push_back(v);
        v = '0; v.busy = 1; v.zhighout = 1; v.hiin = 1; t.push_back(v);
      end
      CUN: begin
        v = '0; v.busy = 1; v.rout = 16'd1 << rb; v.aluen = 1; v.aluop = aop; v.zin = 1;
        t.push_back(v);
        v = '0; v.busy = 1; v.zlowout = 1; v.rin = 16'd1 << ra; t.push_back(v);
      end
      default: begin
        v = '0; v.busy = 1; t.push_back(v);
      end
    endcase
    v = '0; v.busy = 1; v.done = 1; v.illegal = (cls == CIL); t.push_back(v);
    for (int i = 0; i < t.size(); i++) begin
      if (limit <= 0 || i < limit) exp_q.push_back(t[i]);
    end
  endtask

  // Wait (bounded) for Done on the current instance; returns cycles counted
  // with the Start-sampling edge as cycle 1.
  task automatic wait_done(input int first, output int cyc, output bit seen);
    cyc  = first;
    seen = cur_act.done;
    while (!seen && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      seen = cur_act.done;
    end
    if (!seen) begin
      n_vec++; n_miss++;
      $display("FAIL done_timeout (inst %0d): got no Done within %0d cycles", cur, cyc);
      exp_q.delete();
    end
  endtask

  task automatic run_one(input tv_t t);
    int cyc;
    bit seen;
    cur = t.idx;
    ir[t.idx] = t.ir;
    start[t.idx] = 1'b1;
    push_trace(t.cls, t.ir[26:23], t.ir[22:19], t.ir[18:15], t.aop,
               (t.idx == 1) ? 3 : 0, 0);
    @(posedge clk); #1;
    start[t.idx] = 1'b0;
    wait_done(1, cyc, seen);
    if (seen) chk_int("latency", cyc, t.lat);
    @(posedge clk); #1;
    chk_int("queue_drained", exp_q.size(), 0);
  endtask

  // Trace monitor: every cycle, compare against the next queued expectation
  // or, with nothing queued, against all-zero idle outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk_vec("trace", cur_act, mon_e);
      end else begin
        chk_vec("idle_zero", cur_act, '0);
      end
      chk_int("one_bus_driver",
              ((int'(cur_act.pcout) + int'(cur_act.zlowout) + int'(cur_act.zhighout) +
                int'(cur_act.mdrout) + $countones(cur_act.rout)) <= 1) ? 1 : 0, 1);
      chk_int("rout_onehot0", $onehot0(cur_act.rout) ? 1 : 0, 1);
      chk_int("rin_onehot0",  $onehot0(cur_act.rin)  ? 1 : 0, 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  seen;
    logic [31:0] and_ir;

    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      ir[i]    = 32'd0;
    end
    and_ir = mk_ir(5'h05, 4'd4, 4'd3, 4'd7);

    //              idx  IR                              class aluop lat
    tv.push_back('{0, and_ir,                          C3,  4'h0, 7});
    tv.push_back('{0, 32'h7A2B8000,                    CMD, 4'h4, 8});
    tv.push_back('{1, 32'h1A2B8000,                    C3,  4'h2, 10});
    tv.push_back('{0, 32'hF8000000,                    CIL, 4'h0, 5});
    tv.push_back('{2, mk_ir(5'h03, 4'd1, 4'd2, 4'd9),  CIL, 4'h0, 5});
    tv.push_back('{0, 32'h8A180000,                    CUN, 4'hC, 6});
    tv.push_back('{0, mk_ir(5'h04, 4'd2, 4'd1, 4'd15), C3,  4'h3, 7});
    tv.push_back('{0, mk_ir(5'h10, 4'd6, 4'd7, 4'd0),  CMD, 4'h6, 8});
    tv.push_back('{0, mk_ir(5'h12, 4'd15, 4'd0, 4'd0), CUN, 4'hD, 6});
    tv.push_back('{0, mk_ir(5'h0B, 4'd0, 4'd1, 4'd2),  C3,  4'h9, 7});
    tv.push_back('{0, mk_ir(5'h06, 4'd3, 4'd8, 4'd12), C3,  4'h1, 7});
    tv.push_back('{0, mk_ir(5'h07, 4'd1, 4'd2, 4'd3),  C3,  4'hA, 7});
    tv.push_back('{0, mk_ir(5'h08, 4'd5, 4'd6, 4'd9),  C3,  4'hB, 7});
    tv.push_back('{0, mk_ir(5'h09, 4'd14, 4'd13, 4'd11), C3, 4'h7, 7});
    tv.push_back('{0, mk_ir(5'h0A, 4'd10, 4'd9, 4'd8), C3,  4'h8, 7});
    tv.push_back('{0, mk_ir(5'h00, 4'd1, 4'd2, 4'd3),  CIL, 4'h0, 5});
    tv.push_back('{0, mk_ir(5'h0C, 4'd1, 4'd2, 4'd3),  CIL, 4'h0, 5});
    tv.push_back('{2, mk_ir(5'h07, 4'd7, 4'd6, 4'd5),  C3,  4'hA, 7});
    tv.push_back('{2, mk_ir(5'h0F, 4'd8, 4'd0, 4'd0),  CIL, 4'h0, 5});
    tv.push_back('{2, mk_ir(5'h11, 4'd1, 4'd9, 4'd0),  CIL, 4'h0, 5});
    tv.push_back('{2, mk_ir(5'h03, 4'd1, 4'd2, 4'd8),  CIL, 4'h0, 5});
    tv.push_back('{1, mk_ir(5'h0F, 4'd2, 4'd3, 4'd0),  CMD, 4'h4, 11});
    tv.push_back('{1, mk_ir(5'h13, 4'd1, 4'd2, 4'd3),  CIL, 4'h0, 8});
    tv.push_back('{1, mk_ir(5'h12, 4'd1, 4'd2, 4'd0),  CUN, 4'hD, 9});

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cur = i;
      #0;
      chk_vec("reset_state", cur_act, '0);
    end
    cur = 0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    foreach (tv[i]) run_one(tv[i]);

    // Reset during T4 of an add: IDLE with all outputs 0 on the next cycle.
    cur = 0;
    ir[0] = 32'h1A2B8000;
    start[0] = 1'b1;
    push_trace(C3, 4'd4, 4'd5, 4'd7, 4'h2, 0, 6);
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_vec("reset_abort", cur_act, '0);
    chk_int("reset_abort_queue", exp_q.size(), 0);

    // Reset wins over Start in IDLE.
    start[0] = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start[0] = 1'b0;
    chk_int("reset_over_start", int'(cur_act.busy), 0);
    @(posedge clk); #1;

    // Start held high through DONE: ignored there, a second instruction
    // begins only from IDLE, then Start drops so no third one follows.
    ir[0] = and_ir;
    start[0] = 1'b1;
    push_trace(C3, 4'd4, 4'd3, 4'd7, 4'h0, 0, 0);
    push_trace(C3, 4'd4, 4'd3, 4'd7, 4'h0, 0, 0);
    @(posedge clk); #1;
    wait_done(1, cyc, seen);
    if (seen) chk_int("held_start_first_latency", cyc, 7);
    @(posedge clk); #1;
    chk_int("held_start_idle_gap", int'(cur_act.busy), 0);
    @(posedge clk); #1;
    start[0] = 1'b0;
    wait_done(1, cyc, seen);
    if (seen) chk_int("held_start_second_latency", cyc, 7);
    repeat (4) @(posedge clk);
    #1;
    chk_int("final_queue_empty", exp_q.size(), 0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
